// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter
//   Shares one byte-wide memory port between the bridge data loader's write
//   stream and the core's req/ack read/write requester. Loader writes have no
//   backpressure and are buffered in a small FIFO. The loader gets priority once
//   the FIFO fills to URGENT_LEVEL. Otherwise an idle core request wins, and a
//   non-empty FIFO drains when the core is not being served. Everything runs in
//   the clk_memory domain.
//
// Ports
//   clk_memory, reset_n         clock, asynchronous active-low reset
//   load_en/addr/data           loader write strobe and byte (one byte per cycle)
//   load_overflow               sticky: a loader byte was dropped (FIFO full)
//   fifo_level                  current loader FIFO occupancy
//   core_req/wr/addr/wdata      core request, held stable until core_ack
//   core_ack                    one-cycle pulse: core access issued to memory
//   core_rdata/core_rdata_valid read data and its one-cycle valid pulse
//   mem_wr/rd/addr/wdata        registered memory port outputs
//   mem_rdata                   memory read data, READ_LATENCY cycles after mem_rd
module mem_write_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int URGENT_LEVEL = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk_memory,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [ADDR_WIDTH-1:0]         load_addr,
    input  logic [DATA_WIDTH-1:0]         load_data,
    output logic                          load_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          core_req,
    input  logic                          core_wr,
    input  logic [ADDR_WIDTH-1:0]         core_addr,
    input  logic [DATA_WIDTH-1:0]         core_wdata,
    output logic                          core_ack,
    output logic [DATA_WIDTH-1:0]         core_rdata,
    output logic                          core_rdata_valid,
    output logic                          mem_wr,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE,
        READ_WAIT
    } state_t;

    // Loader FIFO storage and control
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LEVEL_W-1:0]    level;

    logic fifo_empty;
    logic fifo_full;
    logic urgent;
    logic core_ok;
    logic pop;
    logic push;
    logic serve_core;
    logic issue_read;

    state_t state;
    state_t state_next;

    // One bit per cycle of read latency; the oldest bit produces core_rdata_valid.
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [READ_LATENCY-1:0] rd_pipe_next;
    logic [DATA_WIDTH-1:0]   rdata_q;

    assign fifo_level = level;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_W'(FIFO_DEPTH));
    assign urgent     = (32'(level) >= URGENT_LEVEL);

    // A request seen while its ack is on the port is the old request, not a new one.
    assign core_ok    = core_req && !core_ack && (state == IDLE);

    // A full FIFO still accepts a byte when the same edge frees an entry.
    assign push       = load_en && (!fifo_full || pop);
    assign issue_read = serve_core && !core_wr;

    // Grant and next state
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        serve_core = 1'b0;
        pop        = 1'b0;
        state_next = state;

        if (urgent) begin
            pop = 1'b1;
        end else if (core_ok) begin
            serve_core = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end

        case (state)
            IDLE:      if (issue_read) state_next = READ_WAIT;
            READ_WAIT: if (core_rdata_valid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_pipe_next[0] = issue_read;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_next[i] = rd_pipe[i-1];
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and level define which
    // entries are meaningful, so clearing the array would only add reset fanout.
    always_ff @(posedge clk_memory) begin
        if (push) begin
            fifo_addr[wr_ptr] <= load_addr;
            fifo_data[wr_ptr] <= load_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            load_overflow    <= 1'b0;
            state            <= IDLE;
            rd_pipe          <= '0;
            core_rdata_valid <= 1'b0;
            core_ack         <= 1'b0;
            mem_wr           <= 1'b0;
            mem_rd           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            rdata_q          <= '0;
        end else begin
            state            <= state_next;
            rd_pipe          <= rd_pipe_next;
            core_rdata_valid <= rd_pipe[READ_LATENCY-1];
            core_ack         <= serve_core;
            mem_wr           <= pop || (serve_core && core_wr);
            mem_rd           <= issue_read;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (load_en && !push) load_overflow <= 1'b1;

            // Address and data hold their last values when nothing is issued.
            if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end else if (serve_core) begin
                mem_addr <= core_addr;
                if (core_wr) mem_wdata <= core_wdata;
            end

            if (core_rdata_valid) rdata_q <= mem_rdata;
        end
    end

    // mem_rdata is only valid in the pulse cycle itself, so the pulse cycle
    // passes it straight through and the register holds it afterwards.
    assign core_rdata = core_rdata_valid ? mem_rdata : rdata_q;

endmodule
